// File: rtl/ram_burst.sv
// ram_burst: single-port synchronous RAM driven by a start/busy/done burst engine.
// A burst latches a start address and a beat count; write beats are qualified
// by din_valid and byte enables, read beats stream out one word per cycle.
//
// Handshake: start is taken only while busy = 0 (including the done cycle);
// a write beat transfers at every rising edge where the engine is in WRITE and
// din_valid = 1; a read beat is presented on dout in every cycle where
// dout_valid = 1 and cannot be back-pressured.
module ram_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     adr,
  input  logic [ADDR_W-1:0]     len,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];
  logic                wr_en;

  // A beat presented together with reset is dropped, so gate on rst_n here.
  assign wr_en     = rst_n && (state == ST_WRITE) && din_valid;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  // Memory array: byte-masked write of the current beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[ptr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Burst engine: state, pointer, beat counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr   <= adr;
            cnt   <= len;
            state <= we ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (din_valid) begin
            ptr <= ptr + 1'b1;
            if (cnt == '0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        ST_READ: begin
          dout       <= mem[ptr];
          dout_valid <= 1'b1;
          ptr        <= ptr + 1'b1;
          if (cnt == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
